led_pattern_engine: RTL and testbench

Parametrised LED chaser with an integrated speed prescaler. Drives an N-bit LED bank in one of four run patterns (fill from MSB, fill from LSB, single running dot, bounce), advancing one step per prescaler tick at one of four selectable rates. It runs directly on the board system clock and drives the board LED pins through registered outputs. It replaces the separate divided-clock chaser arrangement: there is a single clock domain and no generated clocks.

---
 rtl/led_pattern_pkg.sv | 32 +++
 rtl/led_pattern_engine_if.sv | 17 +
 rtl/led_tick_gen.sv | 51 +++++
 rtl/led_pattern_engine.sv | 156 +++++++++++++++
 tb/tb_led_pattern_engine.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pattern_pkg.sv
// Shared types and helpers for the LED pattern engine.
// Optional feature macro: BOUNCE_EN (enables the bounce pattern on mode 3).
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_FILL_MSB = 2'd0,
        MODE_FILL_LSB = 2'd1,
        MODE_DOT      = 2'd2,
        MODE_BOUNCE   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        SPEED_0 = 2'd0,
        SPEED_1 = 2'd1,
        SPEED_2 = 2'd2,
        SPEED_3 = 2'd3
    } speed_e;

    // Prescaler width: enough bits to hold the largest terminal count.
    function automatic int cnt_width(input int d0, input int d1, input int d2, input int d3);
        int m;
        int w;
        m = d0;
        if (d1 > m) m = d1;
        if (d2 > m) m = d2;
        if (d3 > m) m = d3;
        w = $clog2(m);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/led_pattern_engine_if.sv
// Control/status bundle of the LED pattern engine.
// Optional feature macro: BOUNCE_EN (dbg_dir is constant 0 without it).
// Signalling: en/mode/speed are level inputs sampled every clk edge; led is a
// registered level; step and cycle_done are single-cycle pulses that are high
// in the first cycle a new led value is visible. There is no back-pressure.
interface led_pattern_engine_if #(parameter int N_LEDS = 8);
    logic              en;
    logic [1:0]        mode;
    logic [1:0]        speed;
    logic [N_LEDS-1:0] led;
    logic              step;
    logic              cycle_done;
    logic              dbg_dir;

    modport master (output en, mode, speed, input led, step, cycle_done, dbg_dir);
    modport slave  (input en, mode, speed, output led, step, cycle_done, dbg_dir);
endinterface

// File: rtl/led_tick_gen.sv
// Speed prescaler: selects a terminal count and emits a one-cycle tick.
// Optional feature macro: BOUNCE_EN (not used in this file).
module led_tick_gen
    import led_pattern_pkg::*;
#(
    parameter int DIV0 = 50_000_000,
    parameter int DIV1 = 25_000_000,
    parameter int DIV2 = 5_000_000,
    parameter int DIV3 = 2_000_000
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    input  logic   clr,
    input  speed_e speed,
    output logic   tick
);
    localparam int CW = cnt_width(DIV0, DIV1, DIV2, DIV3);

    logic [CW-1:0] cnt_q, cnt_d, term;

    // Terminal count for the selected speed.
    always_comb begin
        term = CW'(DIV3 - 1);
        case (speed)
            SPEED_0: term = CW'(DIV0 - 1);
            SPEED_1: term = CW'(DIV1 - 1);
            SPEED_2: term = CW'(DIV2 - 1);
            default: term = CW'(DIV3 - 1);
        endcase
    end

    // A clear request suppresses the tick on the same edge.
    assign tick = en && !clr && (cnt_q == term);

    // Counter next state: clear on clr or tick, count while enabled, else hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/led_pattern_engine.sv
// LED chaser: four run patterns advanced by a prescaler tick, single clock domain.
// Optional feature macro: BOUNCE_EN (mode 3 bounces; otherwise mode 3 = dot).
module led_pattern_engine
    import led_pattern_pkg::*;
#(
    parameter int N_LEDS = 8,
    parameter int DIV0   = 50_000_000,
    parameter int DIV1   = 25_000_000,
    parameter int DIV2   = 5_000_000,
    parameter int DIV3   = 2_000_000
) (
    input  logic                clk,
    input  logic                reset,
    led_pattern_engine_if.slave bus
);
    localparam logic [N_LEDS-1:0] LED_MSB = {1'b1, {(N_LEDS-1){1'b0}}};
    localparam logic [N_LEDS-1:0] LED_LSB = N_LEDS'(1);

    mode_e             mode_in, mode_q, mode_d;
    speed_e            speed_in, speed_q, speed_d;
    logic [N_LEDS-1:0] led_q, led_d;
    logic              step_q, step_d;
    logic              cycle_done_q, cycle_done_d;
    logic              dir_q;
`ifdef BOUNCE_EN
    logic              dir_d;
`endif
    logic              changed, tick;
    logic              fill_msb_ok, fill_lsb_ok, onehot_ok;

    assign mode_in  = mode_e'(bus.mode);
    assign speed_in = speed_e'(bus.speed);

    // Any mode/speed change restarts the prescaler and pattern on that edge.
    assign changed = (mode_in != mode_q) || (speed_in != speed_q);

    led_tick_gen #(
        .DIV0(DIV0), .DIV1(DIV1), .DIV2(DIV2), .DIV3(DIV3)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (bus.en),
        .clr   (changed),
        .speed (speed_q),
        .tick  (tick)
    );

    // Legal-state tests: fill-MSB = ones packed at the top, fill-LSB = ones
    // packed at the bottom, dot/bounce = exactly one bit set.
    assign fill_msb_ok = ((~led_q) & ((~led_q) + LED_LSB)) == '0;
    assign fill_lsb_ok = (led_q & (led_q + LED_LSB)) == '0;
    assign onehot_ok   = $onehot(led_q);

    // Pattern next state; illegal values restart at the mode's first state.
    always_comb begin
        mode_d       = mode_q;
        speed_d      = speed_q;
        led_d        = led_q;
        step_d       = 1'b0;
        cycle_done_d = 1'b0;
`ifdef BOUNCE_EN
        dir_d        = dir_q;
`endif
        if (changed) begin
            mode_d  = mode_in;
            speed_d = speed_in;
            led_d   = '0;
`ifdef BOUNCE_EN
            dir_d   = 1'b0;
`endif
        end else if (tick) begin
            step_d = 1'b1;
            case (mode_q)
                MODE_FILL_MSB: begin
                    if (led_q == '1) begin
                        led_d        = '0;
                        cycle_done_d = 1'b1;
                    end else if (fill_msb_ok) begin
                        led_d = (led_q >> 1) | LED_MSB;
                    end else begin
                        led_d = LED_MSB;
                    end
                end
                MODE_FILL_LSB: begin
                    if (led_q == '1) begin
                        led_d        = '0;
                        cycle_done_d = 1'b1;
                    end else if (fill_lsb_ok) begin
                        led_d = (led_q << 1) | LED_LSB;
                    end else begin
                        led_d = LED_LSB;
                    end
                end
`ifdef BOUNCE_EN
                MODE_BOUNCE: begin
                    if (!onehot_ok) begin
                        led_d = LED_MSB;
                        dir_d = 1'b0;
                    end else if (!dir_q) begin
                        led_d = led_q >> 1;
                        dir_d = ((led_q >> 1) == LED_LSB);
                    end else begin
                        led_d = led_q << 1;
                        if ((led_q << 1) == LED_MSB) begin
                            dir_d        = 1'b0;
                            cycle_done_d = 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    if (!onehot_ok) begin
                        led_d = LED_MSB;
                    end else if (led_q == LED_LSB) begin
                        led_d        = LED_MSB;
                        cycle_done_d = 1'b1;
                    end else begin
                        led_d = led_q >> 1;
                    end
                end
            endcase
        end
    end

    // State registers; reset captures the live mode/speed as the reference copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q       <= mode_in;
            speed_q      <= speed_in;
            led_q        <= '0;
            step_q       <= 1'b0;
            cycle_done_q <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            speed_q      <= speed_d;
            led_q        <= led_d;
            step_q       <= step_d;
            cycle_done_q <= cycle_done_d;
        end
    end

`ifdef BOUNCE_EN
    // Bounce direction register (0 = moving toward LSB).
    always_ff @(posedge clk) begin
        if (reset) dir_q <= 1'b0;
        else       dir_q <= dir_d;
    end
`else
    assign dir_q = 1'b0;
`endif

    assign bus.led        = led_q;
    assign bus.step       = step_q;
    assign bus.cycle_done = cycle_done_q;
    assign bus.dbg_dir    = dir_q;
endmodule

// File: tb/tb_led_pattern_engine.sv
// Testbench for led_pattern_engine (N_LEDS=8, DIV0..3 = 4,3,2,5).
// Optional feature macro: BOUNCE_EN (reference model follows the same macro).
module tb_led_pattern_engine;
    localparam int N = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    led_pattern_engine_if #(.N_LEDS(N)) bus ();

    led_pattern_engine #(
        .N_LEDS(N), .DIV0(4), .DIV1(3), .DIV2(2), .DIV3(5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // The pattern is a position in a fixed sequence per mode; idle means
    // "dark, next tick starts the sequence".
    int         m_cnt   = 0;
    int         m_ph    = 0;
    bit         m_idle  = 1'b1;
    logic [1:0] m_mode  = 2'd0;
    logic [1:0] m_speed = 2'd0;
    bit         m_step  = 1'b0;
    bit         m_cd    = 1'b0;

    function automatic int div_of(input logic [1:0] s);
        case (s)
            2'd0:    return 4;
            2'd1:    return 3;
            2'd2:    return 2;
            default: return 5;
        endcase
    endfunction

    function automatic int eff_mode(input logic [1:0] m);
`ifdef BOUNCE_EN
        return int'(m);
`else
        return (m == 2'd3) ? 2 : int'(m);
`endif
    endfunction

    function automatic int period(input int em);
        case (em)
            0, 1:    return N + 1;
            2:       return N;
            default: return 2 * (N - 1);
        endcase
    endfunction

    function automatic logic [N-1:0] pattern(input int em, input int ph);
        logic [N-1:0] ones;
        logic [N-1:0] msb;
        logic [N-1:0] lsb;
        ones = '1;
        msb  = {1'b1, {(N-1){1'b0}}};
        lsb  = N'(1);
        case (em)
            0:       return ~(ones >> ph);
            1:       return ~(ones << ph);
            2:       return msb >> ph;
            default: return (ph <= N - 1) ? (msb >> ph) : (lsb << (ph - (N - 1)));
        endcase
    endfunction

    function automatic logic [N-1:0] exp_led();
        if (m_idle) return '0;
        return pattern(eff_mode(m_mode), m_ph);
    endfunction

    function automatic logic exp_dir();
`ifdef BOUNCE_EN
        return (eff_mode(m_mode) == 3) && !m_idle && (m_ph >= N - 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_advance();
        int em;
        em = eff_mode(m_mode);
        if (em <= 1) begin
            if (m_idle) begin
                m_idle = 1'b0;
                m_ph   = 0;
            end
            m_ph = (m_ph + 1) % period(em);
            m_cd = (m_ph == 0);
        end else if (m_idle) begin
            m_idle = 1'b0;
            m_ph   = 0;
        end else begin
            m_ph = (m_ph + 1) % period(em);
            m_cd = (m_ph == 0);
        end
    endtask

    // One clock edge of the specified behaviour, using inputs as set before the edge.
    task automatic model_edge();
        m_step = 1'b0;
        m_cd   = 1'b0;
        if (reset) begin
            m_cnt   = 0;
            m_idle  = 1'b1;
            m_ph    = 0;
            m_mode  = bus.mode;
            m_speed = bus.speed;
        end else if (bus.mode != m_mode || bus.speed != m_speed) begin
            m_mode  = bus.mode;
            m_speed = bus.speed;
            m_cnt   = 0;
            m_idle  = 1'b1;
            m_ph    = 0;
        end else if (bus.en) begin
            if (m_cnt == div_of(m_speed) - 1) begin
                m_cnt  = 0;
                m_step = 1'b1;
                model_advance();
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            check("led", 32'(bus.led), 32'(exp_led()));
            check("step", 32'(bus.step), 32'(m_step));
            check("cycle_done", 32'(bus.cycle_done), 32'(m_cd));
            check("dir", 32'(bus.dbg_dir), 32'(exp_dir()));
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: wait bound expired", tag);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        bus.en    = 1'b1;
        bus.mode  = 2'd0;
        bus.speed = 2'd0;
        reset     = 1'b1;
        run(2);
        check("reset_led", 32'(bus.led), 32'h0);
        reset = 1'b0;

        // Fill from MSB at DIV0=4: first step 4 cycles after reset release.
        run(3);
        check("pre_first_step", 32'(bus.step), 32'h0);
        run(1);
        check("first_step_led", 32'(bus.led), 32'h80);
        check("first_step_pulse", 32'(bus.step), 32'h1);
        run(40);

        // Running dot at DIV2=2.
        bus.mode  = 2'd2;
        bus.speed = 2'd2;
        run(40);

        // Bounce (or dot without the feature) at DIV1=3.
        bus.mode  = 2'd3;
        bus.speed = 2'd1;
        run(90);

        // en dropped while cnt=2, held low 10 cycles, then raised.
        bus.mode  = 2'd0;
        bus.speed = 2'd0;
        run(6);
        for (int k = 0; k < 10 && m_cnt != 2; k++) run(1);
        if (m_cnt != 2) timeout("sync_cnt2");
        bus.en = 1'b0;
        run(10);
        bus.en = 1'b1;
        run(1);
        check("resume_no_step", 32'(bus.step), 32'h0);
        run(1);
        check("resume_step", 32'(bus.step), 32'h1);
        run(5);

        // Speed change 0->3 on the same edge as a pending tick.
        for (int k = 0; k < 10 && m_cnt != 3; k++) run(1);
        if (m_cnt != 3) timeout("sync_pending_tick");
        bus.speed = 2'd3;
        run(1);
        check("chg_no_step", 32'(bus.step), 32'h0);
        check("chg_led_clear", 32'(bus.led), 32'h0);
        run(4);
        check("chg_wait", 32'(bus.step), 32'h0);
        run(1);
        check("chg_next_step", 32'(bus.step), 32'h1);
        check("chg_next_led", 32'(bus.led), 32'h80);

        // Reset in the middle of a fill-LSB run.
        bus.mode  = 2'd1;
        bus.speed = 2'd2;
        for (int k = 0; k < 40 && exp_led() != 8'h07; k++) run(1);
        if (exp_led() != 8'h07) timeout("sync_led07");
        reset = 1'b1;
        run(1);
        check("mid_reset_led", 32'(bus.led), 32'h0);
        check("mid_reset_step", 32'(bus.step), 32'h0);
        check("mid_reset_cd", 32'(bus.cycle_done), 32'h0);
        reset = 1'b0;
        run(20);

        // Random mode/speed/enable/reset activity against the model.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2)       bus.mode  = 2'($urandom_range(0, 3));
            else if (r < 4)  bus.speed = 2'($urandom_range(0, 3));
            else if (r < 8)  bus.en    = 1'b0;
            else if (r < 20) bus.en    = 1'b1;
            reset = ($urandom_range(0, 299) == 0);
            run(1);
        end
        reset = 1'b0;
        run(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
